// File: rtl/dcache_tag_array.sv
// N-way set-associative dcache tag store: per-way valid/dirty/tag, registered
// hit detection, victim selection and tree pseudo-LRU, with a post-reset clear sweep.
module dcache_tag_array #(
   parameter int ADDR_W      = 32,
   parameter int OFFSET_BITS = 5,
   parameter int INDEX_BITS  = 7,
   parameter int WAYS        = 2,
   localparam int TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [ADDR_W-1:0]     addr,
   output logic                  ready,
   output logic                  hit,
   output logic [WAYS-1:0]       hit_way,
   output logic                  hit_dirty,
   output logic [WAYS-1:0]       victim_way,
   output logic                  victim_valid,
   output logic                  victim_dirty,
   output logic [TAG_W-1:0]      victim_tag,
   input  logic                  wen,
   input  logic [INDEX_BITS-1:0] w_index,
   input  logic [WAYS-1:0]       w_way,
   input  logic                  w_valid,
   input  logic                  w_dirty,
   input  logic [TAG_W-1:0]      w_tag,
   input  logic                  touch,
   input  logic [INDEX_BITS-1:0] t_index,
   input  logic [WAYS-1:0]       t_way
);

   localparam int SETS   = 2**INDEX_BITS;
   localparam int LVLS   = $clog2(WAYS);
   localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

   logic [WAYS-1:0]       valid_q [SETS];
   logic [WAYS-1:0]       dirty_q [SETS];
   logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
   logic [INDEX_BITS:0]   cnt;
   logic [INDEX_BITS-1:0] cnt_idx;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      atag;
   logic [PLRU_W-1:0]     plru_rd;
   logic [PLRU_W-1:0]     e_plru;
   logic [WAYS-1:0]       e_valid, e_dirty, match, hit_oh, vic_oh;
   logic [TAG_W-1:0]      e_tag [WAYS];
   logic                  hit_d, vic_v, vic_d;
   logic [TAG_W-1:0]      vic_tag;

   assign cnt_idx = cnt[INDEX_BITS-1:0];
   assign idx     = addr[OFFSET_BITS +: INDEX_BITS];
   assign atag    = addr[ADDR_W-1 -: TAG_W];

   // Each node on the path to the accessed way is set to point away from it.
   function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                    input logic [WAYS-1:0]   way_oh);
      int unsigned w, node, d;
      logic found;
      w = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (way_oh[i] && !found) begin
            w = i;
            found = 1'b1;
         end
      end
      node = 0;
      plru_touch = bits;
      for (int unsigned l = 0; l < LVLS; l++) begin
         d = (w >> (LVLS - 1 - l)) & 1;
         plru_touch[node] = (d == 0);
         node = 2 * node + 1 + d;
      end
   endfunction

   function automatic logic [WAYS-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
      int unsigned node;
      node = 0;
      for (int unsigned l = 0; l < LVLS; l++) begin
         node = 2 * node + 1 + (bits[node] ? 1 : 0);
      end
      plru_victim = '0;
      plru_victim[node - (WAYS - 1)] = 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         ready <= 1'b0;
      end else if (!ready) begin
         if (cnt[INDEX_BITS]) ready <= 1'b1;
         else                 cnt   <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!ready) begin
            if (!cnt[INDEX_BITS]) begin
               valid_q[cnt_idx] <= '0;
               dirty_q[cnt_idx] <= '0;
               for (int unsigned i = 0; i < WAYS; i++) tag_q[cnt_idx][i] <= '0;
            end
         end else if (wen) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
               if (w_way[i]) begin
                  valid_q[w_index][i] <= w_valid;
                  dirty_q[w_index][i] <= w_dirty;
                  tag_q[w_index][i]   <= w_tag;
               end
            end
         end
      end
   end

   generate
      if (WAYS > 1) begin : g_plru
         logic [PLRU_W-1:0] plru_q [SETS];
         always_ff @(posedge clk) begin
            if (!rst) begin
               if (!ready) begin
                  if (!cnt[INDEX_BITS]) plru_q[cnt_idx] <= '0;
               end else if (touch) begin
                  plru_q[t_index] <= plru_touch(plru_q[t_index], t_way);
               end
            end
         end
         assign plru_rd = plru_q[idx];
      end else begin : g_no_plru
         assign plru_rd = '0;
      end
   endgenerate

   // Lookup sees same-cycle writes and touches to its set.
   always_comb begin
      logic fwd;
      logic found;
      e_valid = '0;
      e_dirty = '0;
      match   = '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         fwd        = wen && (w_index == idx) && w_way[i];
         e_valid[i] = fwd ? w_valid : valid_q[idx][i];
         e_dirty[i] = fwd ? w_dirty : dirty_q[idx][i];
         e_tag[i]   = fwd ? w_tag   : tag_q[idx][i];
         match[i]   = e_valid[i] && (e_tag[i] == atag);
      end
      e_plru = (touch && (t_index == idx)) ? plru_touch(plru_rd, t_way) : plru_rd;

      hit_oh = '0;
      hit_d  = 1'b0;
      found  = 1'b0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (match[i] && !found) begin
            hit_oh[i] = 1'b1;
            hit_d     = e_dirty[i];
            found     = 1'b1;
         end
      end

      vic_oh = plru_victim(e_plru);
      found  = 1'b0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (!e_valid[i] && !found) begin
            vic_oh    = '0;
            vic_oh[i] = 1'b1;
            found     = 1'b1;
         end
      end

      vic_v   = 1'b0;
      vic_d   = 1'b0;
      vic_tag = '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (vic_oh[i]) begin
            vic_v   = e_valid[i];
            vic_d   = e_dirty[i];
            vic_tag = e_tag[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !ready) begin
         hit          <= 1'b0;
         hit_way      <= '0;
         hit_dirty    <= 1'b0;
         victim_way   <= '0;
         victim_valid <= 1'b0;
         victim_dirty <= 1'b0;
         victim_tag   <= '0;
      end else if (en) begin
         hit          <= |hit_oh;
         hit_way      <= hit_oh;
         hit_dirty    <= hit_d;
         victim_way   <= vic_oh;
         victim_valid <= vic_v;
         victim_dirty <= vic_d;
         victim_tag   <= vic_tag;
      end
   end

endmodule

// File: tb/tb_dcache_tag_array.sv
// Directed bench for dcache_tag_array at WAYS=4: sweep, hit path, forwarding,
// PLRU victim order, invalid-first victims and mid-sweep reset.
module tb_dcache_tag_array;

   localparam int AW = 32;
   localparam int IB = 7;
   localparam int NW = 4;
   localparam int TW = 20;

   logic          clk = 1'b0;
   logic          rst, en, wen, w_valid, w_dirty, touch;
   logic [AW-1:0] addr;
   logic [IB-1:0] w_index, t_index;
   logic [NW-1:0] w_way, t_way;
   logic [TW-1:0] w_tag;
   logic          ready, hit, hit_dirty, victim_valid, victim_dirty;
   logic [NW-1:0] hit_way, victim_way;
   logic [TW-1:0] victim_tag;

   int checks = 0;
   int errors = 0;

   dcache_tag_array #(.ADDR_W(AW), .OFFSET_BITS(5), .INDEX_BITS(IB), .WAYS(NW)) dut (
      .clk(clk), .rst(rst), .en(en), .addr(addr), .ready(ready),
      .hit(hit), .hit_way(hit_way), .hit_dirty(hit_dirty),
      .victim_way(victim_way), .victim_valid(victim_valid),
      .victim_dirty(victim_dirty), .victim_tag(victim_tag),
      .wen(wen), .w_index(w_index), .w_way(w_way), .w_valid(w_valid),
      .w_dirty(w_dirty), .w_tag(w_tag),
      .touch(touch), .t_index(t_index), .t_way(t_way)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [IB-1:0] i, input logic [NW-1:0] w,
                        input logic v, input logic d, input logic [TW-1:0] t);
      wen = 1'b1; w_index = i; w_way = w; w_valid = v; w_dirty = d; w_tag = t;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; addr = '0; wen = 1'b0; w_index = '0; w_way = '0;
      w_valid = 1'b0; w_dirty = 1'b0; w_tag = '0; touch = 1'b0; t_index = '0; t_way = '0;
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 300 && !ready; i++) step();
      check("init_ready", ready, 1);

      // garbage preload
      write(0, 4'hF, 1, 1, 20'h00000); step();
      write(3, 4'hF, 1, 1, 20'hABCDE); step();
      wen = 1'b0;
      touch = 1'b1; t_index = 0; t_way = 4'b0001; step();
      touch = 1'b0;
      en = 1'b1; addr = 32'h0000_0000; step();
      check("garbage_hit", hit, 1);

      // sweep
      rst = 1'b1; step();
      check("rst_ready", ready, 0);
      check("rst_hit", hit, 0);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         step();
         check("sweep_ready", ready, 0);
         check("sweep_hit", hit, 0);
      end
      step();
      check("sweep_done", ready, 1);
      step();
      check("post_hit", hit, 0);
      check("post_vway", victim_way, 4'b0001);
      check("post_vvalid", victim_valid, 0);
      check("post_vtag", victim_tag, 0);
      en = 1'b0;

      // hit path
      write(3, 4'b0010, 1, 1, 20'hABCDE); step();
      wen = 1'b0;
      en = 1'b1; addr = 32'hABCD_E060; step();
      check("hit2", hit, 1);
      check("hit2_way", hit_way, 4'b0010);
      check("hit2_dirty", hit_dirty, 1);
      check("hit2_vway", victim_way, 4'b0001);
      check("hit2_vvalid", victim_valid, 0);
      addr = 32'hABCD_F060; step();
      check("miss2", hit, 0);
      check("miss2_way", hit_way, 0);
      en = 1'b0; addr = 32'hABCD_E060; step();
      check("hold", hit, 0);

      // write forwarding
      write(4, 4'b0001, 1, 0, 20'h12345);
      en = 1'b1; addr = 32'h1234_5080; step();
      wen = 1'b0; en = 1'b0;
      check("fwd_hit", hit, 1);
      check("fwd_way", hit_way, 4'b0001);
      check("fwd_dirty", hit_dirty, 0);

      // PLRU
      write(5, 4'hF, 1, 0, 20'h55555); step();
      write(5, 4'b1000, 1, 1, 20'h33333); step();
      wen = 1'b0;
      touch = 1'b1; t_index = 5; t_way = 4'b0100; step();
      t_way = 4'b0001; step();
      touch = 1'b0;
      en = 1'b1; addr = 32'h0000_00A0; step();
      check("plru_hit", hit, 0);
      check("plru_vway", victim_way, 4'b1000);
      check("plru_vvalid", victim_valid, 1);
      check("plru_vdirty", victim_dirty, 1);
      check("plru_vtag", victim_tag, 20'h33333);
      touch = 1'b1; t_way = 4'b1000; step();
      touch = 1'b0;
      check("tfwd_vway", victim_way, 4'b0010);
      check("tfwd_vtag", victim_tag, 20'h55555);
      check("tfwd_vdirty", victim_dirty, 0);
      addr = 32'h5555_50A0; step();
      check("multi_hit", hit, 1);
      check("multi_way", hit_way, 4'b0001);
      en = 1'b0;

      // invalid-first
      write(7, 4'b0001, 1, 0, 20'h00007); step();
      wen = 1'b0;
      touch = 1'b1; t_index = 7; t_way = 4'b1000; step();
      touch = 1'b0;
      en = 1'b1; addr = 32'h0000_00E0; step();
      check("inv_hit", hit, 0);
      check("inv_vway", victim_way, 4'b0010);
      check("inv_vvalid", victim_valid, 0);
      en = 1'b0;

      // mid-sweep reset
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 60; i++) step();
      check("mid_ready", ready, 0);
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         step();
         check("resweep_ready", ready, 0);
         if (i == 50) write(2, 4'hF, 1, 1, 20'h22222);
         if (i == 51) wen = 1'b0;
      end
      step();
      check("resweep_done", ready, 1);
      en = 1'b1; addr = 32'h2222_2040; step();
      check("sweep_wen_hit", hit, 0);
      check("sweep_wen_vvalid", victim_valid, 0);
      en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_tag_array.md
Name: dcache_tag_array

Overview:
Parametrised N-way set-associative tag store for the data cache. It replaces the single-way tag RAM with per-way valid/dirty/tag entries, one-cycle registered hit detection across all ways, victim selection and tree pseudo-LRU state. After reset, a sweep clears every set before lookups are honoured. It sits between the dcache controller FSM and the data RAM way-select logic.

Parameters:
- ADDR_W, 32, physical address width.
- OFFSET_BITS, 5, line offset bits (32-byte line).
- INDEX_BITS, 7, set index bits; SETS = 2**INDEX_BITS.
- WAYS, 2, associativity; legal values are 1, 2, 4 and 8.
- TAG_W, derived as ADDR_W-INDEX_BITS-OFFSET_BITS (20 at defaults); not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  lookup enable.
- addr  in  ADDR_W  lookup address; index = addr[OFFSET_BITS+:INDEX_BITS], tag = addr[ADDR_W-1-:TAG_W].
- ready  out  1  high once the clear sweep has completed.
- hit  out  1  registered; some valid way matched the tag of the previous-cycle lookup.
- hit_way  out  WAYS  registered one-hot way that hit; all zero on miss.
- hit_dirty  out  1  registered dirty bit of the hitting way.
- victim_way  out  WAYS  registered one-hot replacement candidate.
- victim_valid  out  1  registered valid bit of the victim.
- victim_dirty  out  1  registered dirty bit of the victim.
- victim_tag  out  TAG_W  registered tag of the victim (writeback address).
- wen  in  1  entry write strobe.
- w_index  in  INDEX_BITS  set to write.
- w_way  in  WAYS  one-hot way(s) to write.
- w_valid  in  1  valid value to write.
- w_dirty  in  1  dirty value to write.
- w_tag  in  TAG_W  tag value to write.
- touch  in  1  PLRU update strobe.
- t_index  in  INDEX_BITS  set to touch.
- t_way  in  WAYS  one-hot way that was accessed.

Behaviour:
- Reset and sweep:
  - On rst, the sweep counter returns to 0, ready goes to 0, and all registered outputs go to 0.
  - While !ready, one set per cycle (index = counter) has all ways cleared (valid=0, dirty=0, tag=0) and its PLRU bits cleared.
  - After SETS cycles, ready rises; latency is SETS+1 cycles from rst deassertion.
  - rst asserted mid-sweep restarts the sweep from index 0.
  - While !ready: wen and touch are ignored, hit=0, and victim outputs are 0.
- Lookup:
  - en sampled at edge k gives outputs valid after edge k+1 (1-cycle latency).
  - Outputs hold their last value when en=0.
- Hit rule:
  - A way hits when valid=1 and the stored tag equals the address tag.
  - If more than one way matches (a controller bug), the lowest-numbered way wins.
- Write-forwarding:
  - If wen and a lookup to the same index coincide, the lookup sees the new entry contents.
  - The same forwarding applies to touch versus the victim computation.
- Victim selection:
  - If any way is invalid, the victim is the lowest-numbered invalid way.
  - Otherwise the victim follows the tree PLRU.
  - WAYS=1: the victim is always way 0 and no PLRU storage exists.
- Tree PLRU:
  - Each set holds WAYS-1 bits. Node 0 is the root; node n has children 2n+1 and 2n+2. A bit value of 1 means the victim lies in the right subtree.
  - touch sets each node on the path to t_way so that it points away from t_way. It takes effect at the edge.
- Simultaneous operations:
  - wen and touch may target the same or different sets in the same cycle; both take effect.
  - A w_way with multiple bits set writes all selected ways.
- wen has no effect on the PLRU state; the controller issues touch explicitly.

Test Plan:
1. Sweep: preload garbage, pulse rst, then hold en=1 → ready=0 for 128 cycles; ready=1 at cycle 129; hit=0 throughout; then a lookup of 0x0000_0000 gives hit=0, victim_way=01, victim_valid=0.
2. Hit path: write set 3 way 1 with tag 0xABCDE, valid=1, dirty=1; look up addr 0xABCDE060 → next cycle hit=1, hit_way=10, hit_dirty=1; look up 0xABCDF060 → hit=0.
3. Forwarding: in the same cycle, wen (set 4, way 0, tag 0x12345, valid=1) and lookup 0x12345080 → next cycle hit=1, hit_way=01.
4. PLRU, WAYS=4: fill set 5 with all ways valid; touch way 2, then touch way 0; look up set 5 with a miss → victim_way=1000, victim_valid=1, victim_tag = way 3's tag.
5. Invalid-first: WAYS=2, set 7 way 0 valid, way 1 invalid, PLRU pointing to way 0 → victim_way=10, victim_valid=0.
6. Mid-sweep reset: assert rst at sweep cycle 60 → ready=0 and the sweep restarts at index 0; ready rises 129 cycles after the second rst deassertion; wen during the sweep leaves no entry written.
